// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared constants and state encoding for the elevator dispatcher
//
// Purpose: default geometry/timing parameters and the dispatcher FSM state
//          encoding shared by elevator_dispatcher and dwell_timer.
// Ports:   none (package).
package elevator_pkg;

  localparam int DEF_NUM_FLOORS   = 4;
  localparam int DEF_DWELL_CYCLES = 8;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_MOVE_UP   = 3'd1;
  localparam logic [2:0] ST_MOVE_DOWN = 3'd2;
  localparam logic [2:0] ST_DWELL     = 3'd3;
  localparam logic [2:0] ST_FAULT     = 3'd4;

endpackage

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - down-counter holding the car stopped at a served floor
//
// Purpose: loads DWELL_CYCLES-1 when the car enters its stop (load) or when a
//          same-floor call re-opens the stop (restart), then counts down to 0.
// Ports:   clk      in   clock
//          rst_n    in   asynchronous active-low reset (count -> 0)
//          load     in   entering the dwell state
//          restart  in   same-floor call while dwelling
//          expired  out  count has reached zero (last dwell cycle)
module dwell_timer
  import elevator_pkg::*;
#(
  parameter int DWELL_CYCLES = DEF_DWELL_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic restart,
  output logic expired
);

  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load || restart) begin
      count <= CW'(DWELL_CYCLES - 1);
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  // Loaded value N-1 counts down through 0, giving exactly N cycles in dwell.
  assign expired = (count == '0);

endmodule

// File: rtl/elevator_dispatcher.sv
// rtl/elevator_dispatcher.sv - call-latching, direction-preserving elevator dispatcher
//
// Purpose: latches floor calls, tracks the car floor from the shaft sensors and
//          issues exactly one of Go_Up / Go_Down / Halt each cycle, stopping at
//          requested floors, dwelling, and locking into FAULT on a limit hit.
// Ports:   CLK               in   clock
//          Reset_n           in   asynchronous active-low reset
//          Call_Req          in   per-floor call buttons
//          Floor_Sensor      in   one-hot when aligned with a floor, else zero
//          Top_Limit_Hit     in   top overtravel switch
//          Bottom_Limit_Hit  in   bottom overtravel switch
//          Go_Up/Go_Down/Halt out registered motion commands (one-hot)
//          Pending           out  latched outstanding calls
//          Current_Floor     out  last floor the car was aligned with
//          Fault             out  limit-switch fault flag
module elevator_dispatcher
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = DEF_NUM_FLOORS,
  parameter int DWELL_CYCLES = DEF_DWELL_CYCLES
) (
  input  logic                          CLK,
  input  logic                          Reset_n,
  input  logic [NUM_FLOORS-1:0]         Call_Req,
  input  logic [NUM_FLOORS-1:0]         Floor_Sensor,
  input  logic                          Top_Limit_Hit,
  input  logic                          Bottom_Limit_Hit,
  output logic                          Go_Up,
  output logic                          Go_Down,
  output logic                          Halt,
  output logic [NUM_FLOORS-1:0]         Pending,
  output logic [$clog2(NUM_FLOORS)-1:0] Current_Floor,
  output logic                          Fault
);

  localparam int FW = $clog2(NUM_FLOORS);

  state_t                state, state_nxt;
  logic                  dir_up, dir_up_nxt;
  logic [NUM_FLOORS-1:0] pending_nxt, clear_mask, call_mask;
  logic [FW-1:0]         sensor_idx;
  logic                  aligned;
  logic                  above, below;
  logic                  dwell_load, dwell_restart, dwell_expired;
  logic                  limit_fault;

  // Sensor decode: only a clean one-hot value counts as being at a floor.
  always_comb begin
    sensor_idx = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (Floor_Sensor[i]) sensor_idx = FW'(i);
    end
  end

  assign aligned = $onehot(Floor_Sensor);

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (Pending[i] && (i > int'(Current_Floor))) above = 1'b1;
      if (Pending[i] && (i < int'(Current_Floor))) below = 1'b1;
    end
  end

  assign limit_fault = (Top_Limit_Hit && (state != ST_MOVE_DOWN)) ||
                       (Bottom_Limit_Hit && (state != ST_MOVE_UP));

  always_comb begin
    state_nxt     = state;
    dir_up_nxt    = dir_up;
    clear_mask    = '0;
    dwell_load    = 1'b0;
    dwell_restart = 1'b0;

    case (state)
      ST_IDLE: begin
        if (aligned && Pending[Current_Floor]) begin
          state_nxt                 = ST_DWELL;
          clear_mask[Current_Floor] = 1'b1;
          dwell_load                = 1'b1;
        end else if (above) begin
          state_nxt  = ST_MOVE_UP;
          dir_up_nxt = 1'b1;
        end else if (below) begin
          state_nxt  = ST_MOVE_DOWN;
          dir_up_nxt = 1'b0;
        end
      end

      ST_MOVE_UP: begin
        if (aligned && Pending[sensor_idx]) begin
          state_nxt              = ST_DWELL;
          clear_mask[sensor_idx] = 1'b1;
          dwell_load             = 1'b1;
        end else if (aligned && (sensor_idx == FW'(NUM_FLOORS - 1))) begin
          state_nxt = ST_IDLE;
        end
      end

      ST_MOVE_DOWN: begin
        if (aligned && Pending[sensor_idx]) begin
          state_nxt              = ST_DWELL;
          clear_mask[sensor_idx] = 1'b1;
          dwell_load             = 1'b1;
        end else if (aligned && (sensor_idx == '0)) begin
          state_nxt = ST_IDLE;
        end
      end

      ST_DWELL: begin
        // A same-floor call re-opens the stop instead of becoming a request.
        if (Call_Req[Current_Floor]) begin
          dwell_restart = 1'b1;
        end else if (dwell_expired) begin
          if (dir_up ? above : below) begin
            state_nxt = dir_up ? ST_MOVE_UP : ST_MOVE_DOWN;
          end else if (dir_up ? below : above) begin
            state_nxt  = dir_up ? ST_MOVE_DOWN : ST_MOVE_UP;
            dir_up_nxt = !dir_up;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end

      ST_FAULT: state_nxt = ST_FAULT;

      default: state_nxt = ST_IDLE;
    endcase

    // Limit hit overrides everything: no service, no direction change.
    if (limit_fault) begin
      state_nxt     = ST_FAULT;
      dir_up_nxt    = dir_up;
      clear_mask    = '0;
      dwell_load    = 1'b0;
      dwell_restart = 1'b0;
    end
  end

  always_comb begin
    call_mask = Call_Req;
    if (state == ST_DWELL) call_mask[Current_Floor] = 1'b0;
    // Clear is applied last so a call on the serving edge is dropped.
    pending_nxt = (Pending | call_mask) & ~clear_mask;
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= ST_IDLE;
      dir_up        <= 1'b1;
      Pending       <= '0;
      Current_Floor <= '0;
      Go_Up         <= 1'b0;
      Go_Down       <= 1'b0;
      Halt          <= 1'b1;
      Fault         <= 1'b0;
    end else begin
      state   <= state_nxt;
      dir_up  <= dir_up_nxt;
      Pending <= pending_nxt;
      if (aligned) Current_Floor <= sensor_idx;
      Go_Up   <= (state_nxt == ST_MOVE_UP);
      Go_Down <= (state_nxt == ST_MOVE_DOWN);
      Halt    <= (state_nxt == ST_IDLE) || (state_nxt == ST_DWELL) ||
                 (state_nxt == ST_FAULT);
      Fault   <= (state_nxt == ST_FAULT);
    end
  end

  dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell_timer (
    .clk     (CLK),
    .rst_n   (Reset_n),
    .load    (dwell_load),
    .restart (dwell_restart),
    .expired (dwell_expired)
  );

endmodule

// File: tb/tb_elevator_dispatcher.sv
// tb/tb_elevator_dispatcher.sv - scoreboard bench for elevator_dispatcher with car plant model
module tb_elevator_dispatcher;

  localparam int NF   = 4;
  localparam int DW   = 8;
  localparam int STEP = 3;
  localparam int MAXP = (NF - 1) * STEP;

  logic          CLK = 1'b0;
  logic          Reset_n;
  logic [NF-1:0] Call_Req;
  logic [NF-1:0] Floor_Sensor;
  logic          Top_Limit_Hit;
  logic          Bottom_Limit_Hit;
  logic          Go_Up, Go_Down, Halt, Fault;
  logic [NF-1:0] Pending;
  logic [1:0]    Current_Floor;

  elevator_dispatcher #(
    .NUM_FLOORS   (NF),
    .DWELL_CYCLES (DW)
  ) dut (
    .CLK              (CLK),
    .Reset_n          (Reset_n),
    .Call_Req         (Call_Req),
    .Floor_Sensor     (Floor_Sensor),
    .Top_Limit_Hit    (Top_Limit_Hit),
    .Bottom_Limit_Hit (Bottom_Limit_Hit),
    .Go_Up            (Go_Up),
    .Go_Down          (Go_Down),
    .Halt             (Halt),
    .Pending          (Pending),
    .Current_Floor    (Current_Floor),
    .Fault            (Fault)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       up;
    logic       down;
    logic       halt;
    logic       fault;
    logic [3:0] pend;
    logic [1:0] floor;
  } obs_t;

  typedef enum int {REST, RISING, FALLING, SERVING, BROKEN} mode_e;

  obs_t  exp_q[$];
  int    errors = 0;
  int    checks = 0;

  mode_e    m_mode;
  bit [3:0] m_calls;
  int       m_floor;
  bit       m_heading_up;
  int       m_hold;
  bit       in_reset;
  int       pos;

  function automatic int sensed(input logic [3:0] s);
    int n = 0;
    int idx = -1;
    for (int i = 0; i < NF; i++) if (s[i]) begin n++; idx = i; end
    return (n == 1) ? idx : -1;
  endfunction

  task automatic model_reset();
    m_mode = REST; m_calls = '0; m_floor = 0; m_heading_up = 1'b1; m_hold = 0;
  endtask

  task automatic model_step(input logic [3:0] call, input logic [3:0] sens,
                            input bit top, input bit bot);
    int       f;
    bit       above, below, hd;
    mode_e    nxt;
    int       serve;
    bit [3:0] accepted;
    f = sensed(sens);
    above = 0; below = 0;
    for (int i = 0; i < NF; i++) begin
      if (m_calls[i] && i > m_floor) above = 1;
      if (m_calls[i] && i < m_floor) below = 1;
    end
    nxt = m_mode; serve = -1; hd = m_heading_up;
    accepted = call;
    if (m_mode == SERVING) accepted[m_floor] = 1'b0;
    case (m_mode)
      REST: begin
        if (f >= 0 && m_calls[m_floor]) begin nxt = SERVING; serve = m_floor; end
        else if (above) begin nxt = RISING; hd = 1; end
        else if (below) begin nxt = FALLING; hd = 0; end
      end
      RISING: begin
        if (f >= 0 && m_calls[f]) begin nxt = SERVING; serve = f; end
        else if (f == NF - 1) nxt = REST;
      end
      FALLING: begin
        if (f >= 0 && m_calls[f]) begin nxt = SERVING; serve = f; end
        else if (f == 0) nxt = REST;
      end
      SERVING: begin
        if (call[m_floor]) m_hold = DW;
        else if (m_hold == 1) begin
          if (m_heading_up ? above : below) nxt = m_heading_up ? RISING : FALLING;
          else if (m_heading_up ? below : above) begin
            nxt = m_heading_up ? FALLING : RISING;
            hd  = !m_heading_up;
          end else nxt = REST;
        end else m_hold--;
      end
      default: ;
    endcase
    if (m_mode != BROKEN && ((top && m_mode != FALLING) || (bot && m_mode != RISING))) begin
      nxt = BROKEN; serve = -1; hd = m_heading_up;
    end
    m_calls = m_calls | accepted;
    if (serve >= 0) m_calls[serve] = 1'b0;
    if (nxt == SERVING && m_mode != SERVING) m_hold = DW;
    if (f >= 0) m_floor = f;
    m_mode = nxt;
    m_heading_up = hd;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.up    = (m_mode == RISING);
    o.down  = (m_mode == FALLING);
    o.halt  = !(o.up || o.down);
    o.fault = (m_mode == BROKEN);
    o.pend  = m_calls;
    o.floor = 2'(m_floor);
    return o;
  endfunction

  function automatic logic [3:0] plant_sensor();
    logic [3:0] s;
    s = '0;
    if (pos % STEP == 0) s[pos / STEP] = 1'b1;
    return s;
  endfunction

  // Car follows the reference commands so the stimulus never depends on the DUT.
  task automatic plant_move();
    if (m_mode == RISING && pos < MAXP) pos++;
    else if (m_mode == FALLING && pos > 0) pos--;
  endtask

  task automatic cycle(input logic [3:0] call, input bit top, input bit bot,
                       input bit glitch, input bit rst_req);
    logic [3:0] sens;
    sens = glitch ? 4'b0110 : plant_sensor();
    Call_Req = call; Floor_Sensor = sens;
    Top_Limit_Hit = top; Bottom_Limit_Hit = bot;
    @(posedge CLK); #1;
    if (!in_reset) model_step(call, sens, top, bot);
    if (rst_req) begin
      Reset_n = 1'b0; in_reset = 1; model_reset();
    end else if (in_reset) begin
      Reset_n = 1'b1; in_reset = 0;
    end
    exp_q.push_back(model_obs());
    plant_move();
  endtask

  task automatic run_idle(input int n);
    repeat (n) cycle(4'b0000, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{Go_Up, Go_Down, Halt, Fault, Pending, Current_Floor};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got up=%b dn=%b halt=%b flt=%b pend=%b floor=%0d expected up=%b dn=%b halt=%b flt=%b pend=%b floor=%0d",
                   $time, a.up, a.down, a.halt, a.fault, a.pend, a.floor,
                   e.up, e.down, e.halt, e.fault, e.pend, e.floor);
        end
      end
    end
  end

  initial begin : stimulus
    int broken_for;
    Reset_n = 1'b0; in_reset = 1; pos = 0;
    Call_Req = '0; Floor_Sensor = 4'b0001; Top_Limit_Hit = 0; Bottom_Limit_Hit = 0;
    model_reset();

    // Reset held with all calls pressed, then release: calls latch one edge later.
    repeat (3) cycle(4'b1111, 0, 0, 0, 1);
    cycle(4'b1111, 0, 0, 0, 0);
    cycle(4'b1111, 0, 0, 0, 0);
    run_idle(90);

    // Return to floor 0, then a single call for floor 2.
    cycle(4'b0001, 0, 0, 0, 0);
    run_idle(40);
    cycle(4'b0100, 0, 0, 0, 0);
    run_idle(30);

    // Back at floor 0: head up for 3, add floor 0 while passing floor 1.
    cycle(4'b0001, 0, 0, 0, 0);
    run_idle(30);
    cycle(4'b1000, 0, 0, 0, 0);
    for (int k = 0; k < 20 && pos != STEP; k++) cycle(4'b0000, 0, 0, 0, 0);
    cycle(4'b0001, 0, 0, 0, 0);
    run_idle(60);

    // Dwell at floor 2 restarted by a same-floor call.
    cycle(4'b0100, 0, 0, 0, 0);
    for (int k = 0; k < 40 && m_mode != SERVING; k++) cycle(4'b0000, 0, 0, 0, 0);
    run_idle(3);
    cycle(4'b0100, 0, 0, 0, 0);
    run_idle(20);

    // Top limit while rising -> fault; calls still latch; reset mid-fault.
    cycle(4'b1000, 0, 0, 0, 0);
    for (int k = 0; k < 20 && m_mode != RISING; k++) cycle(4'b0000, 0, 0, 0, 0);
    cycle(4'b0000, 1, 0, 0, 0);
    cycle(4'b0011, 0, 0, 0, 0);
    run_idle(5);
    cycle(4'b0000, 0, 0, 0, 1);
    cycle(4'b0000, 0, 0, 0, 0);

    // Top limit while falling is tolerated; bottom limit while idle is not.
    cycle(4'b1000, 0, 0, 0, 0);
    run_idle(40);
    cycle(4'b0001, 0, 0, 0, 0);
    run_idle(2);
    cycle(4'b0000, 1, 0, 0, 0);
    run_idle(40);
    cycle(4'b0000, 0, 1, 0, 0);
    run_idle(3);
    cycle(4'b0000, 0, 0, 0, 1);
    cycle(4'b0000, 0, 0, 0, 0);

    // Multi-hot sensor glitch while travelling with floors 1 and 2 pending.
    cycle(4'b0110, 0, 0, 0, 0);
    for (int k = 0; k < 20 && pos != 1; k++) cycle(4'b0000, 0, 0, 0, 0);
    cycle(4'b0000, 0, 0, 1, 0);
    run_idle(60);

    // Randomized traffic with occasional limit hits and resets.
    broken_for = 0;
    for (int n = 0; n < 2000; n++) begin
      logic [3:0] c;
      bit top, bot, rst;
      c   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      top = ($urandom_range(0, 399) == 0);
      bot = ($urandom_range(0, 399) == 0);
      broken_for = (m_mode == BROKEN) ? broken_for + 1 : 0;
      rst = ($urandom_range(0, 499) == 0) || (broken_for > 12);
      cycle(c, top, bot, 0, rst);
    end

    @(negedge CLK); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/elevator_dispatcher.md
ELEVATOR_DISPATCHER -- requirements
Module: elevator_dispatcher

Interface
REQ-001 Parameter NUM_FLOORS, default 4, number of served floors (floor 0 = bottom).
REQ-002 Parameter DWELL_CYCLES, default 8, cycles the car is held stopped at a served floor.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 Call_Req  input  NUM_FLOORS  per-floor call button, bit i = request for floor i, any-length pulse.
REQ-006 Floor_Sensor  input  NUM_FLOORS  shaft sensors, one-hot when car aligned with floor, all-zero between floors.
REQ-007 Top_Limit_Hit  input  1  top overtravel switch.
REQ-008 Bottom_Limit_Hit  input  1  bottom overtravel switch.
REQ-009 Go_Up  output  1  command to downstream elevator FSM: move up.
REQ-010 Go_Down  output  1  command to downstream elevator FSM: move down.
REQ-011 Halt  output  1  command to downstream elevator FSM: stop/hold.
REQ-012 Pending  output  NUM_FLOORS  latched outstanding requests.
REQ-013 Current_Floor  output  $clog2(NUM_FLOORS)  last floor the car was aligned with.
REQ-014 Fault  output  1  limit-switch fault flag.

Function
REQ-015 Go_Up, Go_Down, Halt SHALL be registered Moore outputs, exactly one high every cycle out of reset.
REQ-016 States: IDLE (Halt), MOVE_UP (Go_Up), MOVE_DOWN (Go_Down), DWELL (Halt), FAULT (Halt, Fault=1).
REQ-017 Pending[i] SHALL set the cycle after Call_Req[i] is sampled high, and hold until cleared by service or reset.
REQ-018 Current_Floor SHALL update to index of Floor_Sensor when it is exactly one-hot; zero or multi-hot values SHALL leave it unchanged.
REQ-019 "Above"/"below" = any Pending bit with index greater/less than Current_Floor.
REQ-020 IDLE: if car aligned and Pending[Current_Floor] -> DWELL; else if above -> MOVE_UP; else if below -> MOVE_DOWN; else stay; above wins over below.
REQ-021 MOVE_UP/MOVE_DOWN: when Floor_Sensor one-hot at floor f with Pending[f]=1 -> DWELL next cycle, Pending[f] cleared same edge.
REQ-022 On entering DWELL the dwell counter SHALL load DWELL_CYCLES-1 and decrement each cycle; DWELL lasts exactly DWELL_CYCLES cycles.
REQ-023 DWELL expiry: continue previous travel direction if requests remain that way, else reverse if requests remain opposite, else IDLE.
REQ-024 Call_Req[Current_Floor] during DWELL SHALL restart the dwell counter and SHALL NOT set Pending.
REQ-025 Call_Req[f] arriving on the same edge Pending[f] is cleared: clear wins.
REQ-026 MOVE_UP reaching floor NUM_FLOORS-1 with nothing pending there -> DWELL-free transition to IDLE; same for MOVE_DOWN at floor 0.
REQ-027 Top_Limit_Hit while not MOVE_DOWN, or Bottom_Limit_Hit while not MOVE_UP -> FAULT next cycle.
REQ-028 FAULT SHALL be left only by reset; Pending continues to latch calls in FAULT.

Reset
REQ-029 Reset_n low SHALL asynchronously force IDLE, Halt=1, Go_Up=0, Go_Down=0, Pending=0, Current_Floor=0, Fault=0, dwell counter=0, travel direction=up.
REQ-030 Reset assertion mid-travel or mid-dwell SHALL discard all pending calls; release is synchronous to CLK.

Structure
REQ-031 Shared package elevator_pkg SHALL hold state encoding, default NUM_FLOORS and DWELL_CYCLES.
REQ-032 Dwell countdown SHALL be a sub-module dwell_timer (load, restart, expired outputs).
REQ-033 Total RTL 120-400 lines; no latches; single clock domain.

Verification
REQ-034 Reset with Call_Req=4'b1111 held -> Halt=1, Pending=0 during reset; Pending=4'b1111 one cycle after release.
REQ-035 Car at floor 0, pulse Call_Req=4'b0100 -> Go_Up until Floor_Sensor=4'b0100, then Halt for 8 cycles, Pending=0, Current_Floor=2, then IDLE.
REQ-036 Car at floor 1 moving up, Pending=4'b1001 -> serve floor 3 first, then Go_Down to floor 0.
REQ-037 During DWELL at floor 2, pulse Call_Req=4'b0100 -> dwell restarts, total Halt = 8 cycles after last pulse, Pending[2]=0.
REQ-038 Top_Limit_Hit=1 while Go_Up=1 -> Fault=1, Halt=1 next cycle; new calls latch in Pending; only Reset_n clears Fault.
REQ-039 Floor_Sensor=4'b0110 while moving -> Current_Floor unchanged, no stop, no Pending clear.
